// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT buffer behind the UART receiver: synchronises the receiver's
// byte-complete level, turns each rising edge into one push, and streams bytes out.
module uart_rx_fifo #(
    parameter int DEPTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx_done,
    input  logic [7:0]                 rx_data,
    output logic                       m_valid,
    output logic [7:0]                 m_data,
    input  logic                       m_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    input  logic                       clr_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   done_dly_q;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   ovf_q, ovf_d;
    logic [7:0]             mem [DEPTH];
    logic                   push, pop, wr_en, drop;

    // Flops preset to 1 so a done level already high at reset release is not an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '1;
            done_dly_q <= 1'b1;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], rx_done};
            done_dly_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign push  = sync_q[SYNC_STAGES-1] & ~done_dly_q;
    assign pop   = m_valid & m_ready;
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A drop in the same cycle as a clear must leave the flag set.
        if (drop)         ovf_d = 1'b1;
        else if (clr_ovf) ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) mem[wr_ptr_q] <= rx_data;
    end

    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign m_valid  = ~empty;
    assign m_data   = mem[rd_ptr_q];
    assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: expected bytes are queued when sent and
// compared by a monitor whenever the consumer side pops.
module tb_uart_rx_fifo;
    logic       clk = 1'b0;
    logic       rst;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready;
    logic [4:0] count;
    logic       full, empty, overflow, clr_ovf;

    int  n_checks = 0;
    int  n_errors = 0;
    bit  rnd_ready = 1'b0;
    logic [7:0] exp_q[$];

    uart_rx_fifo #(.DEPTH(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .rx_done(rx_done), .rx_data(rx_data),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .count(count), .full(full), .empty(empty),
        .overflow(overflow), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) begin
            m_ready = 1'($urandom_range(0, 1));
            check_eq("count_max", {31'd0, count <= 5'd16}, 32'd1);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit expect_kept);
        rx_data = b;
        rx_done = 1'b1;
        if (expect_kept) exp_q.push_back(b);
        repeat (6) tick();
        rx_done = 1'b0;
        repeat (6) tick();
    endtask

    task automatic drain();
        int guard;
        m_ready = 1'b1;
        guard = 0;
        while (!empty && guard < 200) begin
            tick();
            guard++;
        end
        m_ready = 1'b0;
        check_eq("drain_empty", {31'd0, empty}, 32'd1);
        check_eq("drain_queue", exp_q.size(), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) check_eq("pop_extra", exp_q.size(), 32'd1);
            else check_eq("pop_data", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
        end
    end

    initial begin
        rst = 1'b1; rx_done = 1'b0; rx_data = 8'h00; m_ready = 1'b0; clr_ovf = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_eq("rst_count", {27'd0, count}, 32'd0);
        check_eq("rst_empty", {31'd0, empty}, 32'd1);
        check_eq("rst_full", {31'd0, full}, 32'd0);
        check_eq("rst_valid", {31'd0, m_valid}, 32'd0);
        check_eq("rst_ovf", {31'd0, overflow}, 32'd0);

        // Single byte, long done level, latency.
        rx_data = 8'hA5; rx_done = 1'b1; exp_q.push_back(8'hA5);
        tick();
        check_eq("lat_n0", {31'd0, m_valid}, 32'd0);
        tick();
        check_eq("lat_n1", {31'd0, m_valid}, 32'd0);
        tick();
        check_eq("lat_n2", {31'd0, m_valid}, 32'd1);
        check_eq("single_data", {24'd0, m_data}, 32'hA5);
        repeat (47) tick();
        rx_done = 1'b0;
        repeat (3) tick();
        check_eq("single_count", {27'd0, count}, 32'd1);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check_eq("single_empty", {31'd0, empty}, 32'd1);
        check_eq("single_cnt0", {27'd0, count}, 32'd0);

        // Fill.
        for (int i = 0; i < 16; i++) send(8'(i), 1'b1);
        check_eq("fill_full", {31'd0, full}, 32'd1);
        check_eq("fill_count", {27'd0, count}, 32'd16);
        check_eq("fill_ovf", {31'd0, overflow}, 32'd0);

        // Drop while full.
        send(8'hEE, 1'b0);
        check_eq("drop_count", {27'd0, count}, 32'd16);
        check_eq("drop_ovf", {31'd0, overflow}, 32'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check_eq("clr_ovf", {31'd0, overflow}, 32'd0);

        // Drop and clear on the same edge: set wins.
        rx_data = 8'hEE; rx_done = 1'b1;
        repeat (2) tick();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check_eq("drop_clr_same", {31'd0, overflow}, 32'd1);
        repeat (3) tick();
        rx_done = 1'b0;
        repeat (6) tick();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check_eq("clr_ovf2", {31'd0, overflow}, 32'd0);

        // Push into a full FIFO on the same edge as a pop.
        rx_data = 8'h55; rx_done = 1'b1; exp_q.push_back(8'h55);
        repeat (2) tick();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check_eq("fullpop_count", {27'd0, count}, 32'd16);
        check_eq("fullpop_ovf", {31'd0, overflow}, 32'd0);
        repeat (3) tick();
        rx_done = 1'b0;
        repeat (6) tick();
        drain();

        // Wrap-around with random backpressure.
        rnd_ready = 1'b1;
        for (int i = 0; i < 40; i++) send(8'($urandom_range(0, 255)), 1'b1);
        rnd_ready = 1'b0;
        drain();
        check_eq("stream_ovf", {31'd0, overflow}, 32'd0);

        // Mid-operation reset discards contents.
        for (int i = 0; i < 5; i++) send(8'(8'h30 + i), 1'b1);
        check_eq("pre_rst_count", {27'd0, count}, 32'd5);
        rst = 1'b1;
        tick();
        exp_q.delete();
        rst = 1'b0;
        check_eq("mid_rst_count", {27'd0, count}, 32'd0);
        check_eq("mid_rst_empty", {31'd0, empty}, 32'd1);
        check_eq("mid_rst_ovf", {31'd0, overflow}, 32'd0);

        // rx_done high across reset release, then a fresh rising edge.
        rx_data = 8'h77; rx_done = 1'b1;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (10) tick();
        check_eq("held_done_nopush", {27'd0, count}, 32'd0);
        rx_done = 1'b0;
        repeat (4) tick();
        rx_data = 8'h9C; rx_done = 1'b1; exp_q.push_back(8'h9C);
        repeat (6) tick();
        check_eq("edge_push1", {27'd0, count}, 32'd1);
        repeat (20) tick();
        check_eq("edge_push_once", {27'd0, count}, 32'd1);
        rx_done = 1'b0;
        tick();
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
